// File: rtl/pwm_timer_pkg.sv
// Shared timer definitions: controller state encoding and default widths
// used by the update scheduler and its repetition counter.
package pwm_timer_pkg;

    localparam int PWM_WIDTH     = 8;
    localparam int PWM_RCR_WIDTH = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } pwm_state_e;

endpackage

// File: rtl/pwm_rep_counter.sv
// Repetition down-counter: counts enabled overflows and fires a trigger when
// the count has expired (or when forced), reloading from the preload value.
module pwm_rep_counter
    import pwm_timer_pkg::*;
#(
    parameter int RCR_WIDTH = PWM_RCR_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 ovf_en_i,
    input  logic                 udis_i,
    input  logic                 force_i,
    input  logic [RCR_WIDTH-1:0] preload_i,
    output logic                 trigger_o,
    output logic [RCR_WIDTH-1:0] rep_cnt_o
);

    localparam logic [RCR_WIDTH-1:0] CNT_ONE = RCR_WIDTH'(1);

    logic [RCR_WIDTH-1:0] rep_cnt_q;
    logic [RCR_WIDTH-1:0] rep_cnt_d;
    logic                 expired;
    logic                 trig_ovf;

    assign expired   = (rep_cnt_q == '0);
    assign trig_ovf  = ovf_en_i && expired && !udis_i;
    assign trigger_o = force_i || trig_ovf;

    // An expired count with updates disabled holds at zero, so the first
    // overflow after re-enabling updates fires straight away.
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        if (trigger_o) begin
            rep_cnt_d = preload_i;
        end else if (ovf_en_i && !expired) begin
            rep_cnt_d = rep_cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end

    assign rep_cnt_o = rep_cnt_q;

endmodule

// File: rtl/pwm_update_ctrl.sv
// Update-event scheduler and dead-time preload register with sticky write
// lock, feeding update_event_i / dtg_preload_i of pwm_oc_deadtime.
module pwm_update_ctrl
    import pwm_timer_pkg::*;
#(
    parameter int WIDTH     = PWM_WIDTH,
    parameter int RCR_WIDTH = PWM_RCR_WIDTH
) (
    input  logic                 clk_psc_i,
    input  logic                 rst_n_i,
    input  logic                 cen_i,
    input  logic                 ovf_i,
    input  logic                 ug_i,
    input  logic                 udis_i,
    input  logic [RCR_WIDTH-1:0] rcr_preload_i,
    input  logic                 cfg_wr_i,
    input  logic [WIDTH-1:0]     cfg_dtg_i,
    input  logic                 lock_set_i,
    input  logic                 uif_clr_i,
    output logic                 update_event_o,
    output logic [WIDTH-1:0]     dtg_preload_o,
    output logic                 cfg_ack_o,
    output logic                 cfg_err_o,
    output logic                 locked_o,
    output logic [RCR_WIDTH-1:0] rep_cnt_o,
    output logic                 uif_o
);

    pwm_state_e state_q, state_d;

    logic             trigger;
    logic             ovf_en;
    logic             update_q, update_d;
    logic             uif_q, uif_d;
    logic [WIDTH-1:0] dtg_q, dtg_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             locked_q, locked_d;

    always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ovf_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cen_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                ovf_en = ovf_i;
                if (!cen_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    pwm_rep_counter #(
        .RCR_WIDTH (RCR_WIDTH)
    ) u_rep_counter (
        .clk_i     (clk_psc_i),
        .rst_n_i   (rst_n_i),
        .ovf_en_i  (ovf_en),
        .udis_i    (udis_i),
        .force_i   (ug_i),
        .preload_i (rcr_preload_i),
        .trigger_o (trigger),
        .rep_cnt_o (rep_cnt_o)
    );

    // The write is judged against the lock state before this edge, so a
    // write paired with lock_set_i still lands.
    always_comb begin
        update_d = trigger;
        uif_d    = trigger ? 1'b1 : (uif_clr_i ? 1'b0 : uif_q);
        dtg_d    = dtg_q;
        ack_d    = cfg_wr_i;
        err_d    = cfg_wr_i && locked_q;
        locked_d = locked_q || lock_set_i;
        if (cfg_wr_i && !locked_q) begin
            dtg_d = cfg_dtg_i;
        end
    end

    always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            update_q <= 1'b0;
            uif_q    <= 1'b0;
            dtg_q    <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            update_q <= update_d;
            uif_q    <= uif_d;
            dtg_q    <= dtg_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            locked_q <= locked_d;
        end
    end

    assign update_event_o = update_q;
    assign uif_o          = uif_q;
    assign dtg_preload_o  = dtg_q;
    assign cfg_ack_o      = ack_q;
    assign cfg_err_o      = err_q;
    assign locked_o       = locked_q;

endmodule

// File: tb/tb_pwm_update_ctrl.sv
// Bench for pwm_update_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the update rules.
module tb_pwm_update_ctrl;

    localparam int W  = 8;
    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cen, ovf, ug, udis, wr, lock_set, uif_clr;
    logic [RW-1:0] rcr;
    logic [W-1:0]  dtg_in;

    logic          update_event, cfg_ack, cfg_err, locked, uif;
    logic [W-1:0]  dtg_preload;
    logic [RW-1:0] rep_cnt;

    int tests = 0;
    int fails = 0;

    // behavioural model state
    bit            m_run;
    int            m_rep;
    bit            m_upd, m_uif, m_ack, m_err, m_locked;
    logic [W-1:0]  m_dtg;
    int            cycle;
    int            exp_upd_q[$];

    always #5 clk = ~clk;

    pwm_update_ctrl #(.WIDTH(W), .RCR_WIDTH(RW)) dut (
        .clk_psc_i      (clk),
        .rst_n_i        (rst_n),
        .cen_i          (cen),
        .ovf_i          (ovf),
        .ug_i           (ug),
        .udis_i         (udis),
        .rcr_preload_i  (rcr),
        .cfg_wr_i       (wr),
        .cfg_dtg_i      (dtg_in),
        .lock_set_i     (lock_set),
        .uif_clr_i      (uif_clr),
        .update_event_o (update_event),
        .dtg_preload_o  (dtg_preload),
        .cfg_ack_o      (cfg_ack),
        .cfg_err_o      (cfg_err),
        .locked_o       (locked),
        .rep_cnt_o      (rep_cnt),
        .uif_o          (uif)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_rep = 0; m_upd = 0; m_uif = 0;
        m_ack = 0; m_err = 0; m_locked = 0; m_dtg = '0;
        exp_upd_q.delete();
    endtask

    // Apply the update rules for one clock edge using the inputs present.
    task automatic model_edge();
        bit fire;
        fire = ug || (m_run && ovf && m_rep == 0 && !udis);
        if (fire)                           m_rep = int'(rcr);
        else if (m_run && ovf && m_rep > 0) m_rep = m_rep - 1;
        m_upd = fire;
        if (fire) exp_upd_q.push_back(cycle + 1);
        if (fire)         m_uif = 1;
        else if (uif_clr) m_uif = 0;
        m_ack = wr;
        m_err = wr && m_locked;
        if (wr && !m_locked) m_dtg = dtg_in;
        m_locked = m_locked || lock_set;
        m_run = cen;
    endtask

    task automatic check_all();
        bit exp_pulse;
        exp_pulse = 0;
        while (exp_upd_q.size() > 0 && exp_upd_q[0] < cycle) void'(exp_upd_q.pop_front());
        if (exp_upd_q.size() > 0 && exp_upd_q[0] == cycle) begin
            exp_pulse = 1;
            void'(exp_upd_q.pop_front());
        end
        chk("update_event", {31'd0, update_event}, {31'd0, exp_pulse});
        chk("uif", {31'd0, uif}, {31'd0, m_uif});
        chk("rep_cnt", 32'(rep_cnt), 32'(m_rep));
        chk("dtg_preload", 32'(dtg_preload), 32'(m_dtg));
        chk("cfg_ack", {31'd0, cfg_ack}, {31'd0, m_ack});
        chk("cfg_err", {31'd0, cfg_err}, {31'd0, m_err});
        chk("locked", {31'd0, locked}, {31'd0, m_locked});
    endtask

    task automatic clear_pulses();
        ovf = 0; ug = 0; wr = 0; lock_set = 0; uif_clr = 0;
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        cycle++;
        @(negedge clk);
        check_all();
        clear_pulses();
    endtask

    task automatic async_reset_check();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_update", {31'd0, update_event}, 32'd0);
        chk("rst_uif", {31'd0, uif}, 32'd0);
        chk("rst_rep", 32'(rep_cnt), 32'd0);
        chk("rst_dtg", 32'(dtg_preload), 32'd0);
        chk("rst_ack", {31'd0, cfg_ack}, 32'd0);
        chk("rst_err", {31'd0, cfg_err}, 32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int upd_tbl[6];
        int rep_tbl[6];
        upd_tbl = '{1, 0, 0, 1, 0, 0};
        rep_tbl = '{2, 1, 0, 2, 1, 0};
        cycle = 0;
        rst_n = 1'b0;
        cen = 0; udis = 0; rcr = '0; dtg_in = '0;
        clear_pulses();
        model_reset();
        @(negedge clk);
        async_reset_check();
        tick();

        // Enable, rcr=0: every overflow updates one cycle later
        cen = 1; tick(); tick();
        for (int i = 0; i < 4; i++) begin
            ovf = 1; tick();
            chk("ovf_rcr0_pulse", {31'd0, update_event}, 32'd1);
            chk("ovf_rcr0_uif", {31'd0, uif}, 32'd1);
            tick();
        end

        // Repetition count of 2: updates on 1st and 4th overflow only
        rcr = 8'd2;
        for (int i = 0; i < 6; i++) begin
            ovf = 1; tick();
            chk("rcr2_pulse", {31'd0, update_event}, 32'(upd_tbl[i]));
            chk("rcr2_rep", 32'(rep_cnt), 32'(rep_tbl[i]));
            tick();
        end

        // Update disable holds an expired count; software update overrides it
        rcr = 8'd0;
        udis = 1;
        for (int i = 0; i < 3; i++) begin
            ovf = 1; tick();
            chk("udis_blocked", {31'd0, update_event}, 32'd0);
        end
        udis = 0; ovf = 1; tick();
        chk("udis_release", {31'd0, update_event}, 32'd1);
        udis = 1; rcr = 8'd5; ug = 1; tick();
        chk("ug_udis_pulse", {31'd0, update_event}, 32'd1);
        chk("ug_udis_rep", 32'(rep_cnt), 32'd5);
        udis = 0;

        // Dead-time writes, alone and in the same cycle as a trigger
        wr = 1; dtg_in = 8'd3; tick();
        chk("wr3_dtg", 32'(dtg_preload), 32'd3);
        ug = 1; tick();
        chk("wr3_update_dtg", 32'(dtg_preload), 32'd3);
        rcr = 8'd0; ovf = 1; ug = 1; tick();
        wr = 1; dtg_in = 8'd5; ovf = 1; tick();
        chk("wr5_pulse", {31'd0, update_event}, 32'd1);
        chk("wr5_dtg", 32'(dtg_preload), 32'd5);

        // Lock together with a write: write lands, later writes rejected
        lock_set = 1; wr = 1; dtg_in = 8'd9; tick();
        chk("lockwr_err", {31'd0, cfg_err}, 32'd0);
        chk("lockwr_dtg", 32'(dtg_preload), 32'd9);
        wr = 1; dtg_in = 8'd7; tick();
        chk("locked_ack", {31'd0, cfg_ack}, 32'd1);
        chk("locked_err", {31'd0, cfg_err}, 32'd1);
        chk("locked_dtg", 32'(dtg_preload), 32'd9);

        // Mid-count reset
        rcr = 8'd3; ug = 1; tick();
        ovf = 1; tick();
        async_reset_check();
        tick();
        chk("post_reset_update", {31'd0, update_event}, 32'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                async_reset_check();
            end
            if ($urandom_range(0, 15) == 0) cen = ~cen;
            if ($urandom_range(0, 11) == 0) udis = ~udis;
            rcr      = 8'($urandom_range(0, 3));
            ovf      = ($urandom_range(0, 2) == 0);
            ug       = ($urandom_range(0, 9) == 0);
            wr       = ($urandom_range(0, 5) == 0);
            dtg_in   = 8'($urandom);
            lock_set = ($urandom_range(0, 99) == 0);
            uif_clr  = ($urandom_range(0, 4) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pwm_update_ctrl.md
Name: pwm_update_ctrl

Overview:
Update-event scheduler and dead-time configuration controller for the pwm_oc_deadtime output stage.
- Decides when the dead-time shadow register loads, by issuing update_event_o from counter overflows, a repetition counter and software update requests.
- Owns the dead-time preload register and its CPU write handshake, including a sticky write-lock.
- Sits between the timer counter/register interface and pwm_oc_deadtime, driving its update_event_i and dtg_preload_i.

Parameters:
WIDTH, 8, dead-time preload width; must equal the WIDTH of the driven pwm_oc_deadtime.
RCR_WIDTH, 8, repetition counter width.

Ports:
clk_psc_i      input   1          prescaled timer clock; single clock domain
rst_n_i        input   1          asynchronous active-low reset
cen_i          input   1          counter enable level; 0 suppresses overflow-driven updates
ovf_i          input   1          one-cycle counter overflow/underflow pulse
ug_i           input   1          software update-generation pulse
udis_i         input   1          update-disable level; blocks overflow-driven updates only
rcr_preload_i  input   RCR_WIDTH  repetition count preload
cfg_wr_i       input   1          dead-time write request, one-cycle pulse
cfg_dtg_i      input   WIDTH      dead-time write data
lock_set_i     input   1          pulse; sets the sticky config lock
uif_clr_i      input   1          pulse; clears uif_o
update_event_o output  1          one-cycle update pulse to pwm_oc_deadtime.update_event_i
dtg_preload_o  output  WIDTH      dead-time preload value to pwm_oc_deadtime.dtg_preload_i
cfg_ack_o      output  1          one-cycle write-completion pulse
cfg_err_o      output  1          qualifies cfg_ack_o; 1 = write rejected
locked_o       output  1          lock status
rep_cnt_o      output  RCR_WIDTH  current repetition count
uif_o          output  1          sticky update interrupt flag

Behaviour:
- Clock and reset: one clock, clk_psc_i; reset rst_n_i is asynchronous, active-low. All state is registered.
- Reset values: all outputs 0; FSM in IDLE.
- FSM states IDLE and RUN.
  - IDLE to RUN when cen_i=1.
  - RUN to IDLE when cen_i=0.
  - Transition takes effect at the next edge.
  - ovf_i is ignored in IDLE; ug_i is honoured in both states.
- Overflow handling, in RUN with ovf_i=1 (define trig_ovf = rep_cnt==0 and udis_i=0):
  - rep_cnt==0 and udis_i=0: trigger update; rep_cnt <= rcr_preload_i.
  - rep_cnt!=0: rep_cnt <= rep_cnt-1, independent of udis_i.
  - rep_cnt==0 and udis_i=1: no update; rep_cnt held at 0. The first ovf_i after udis_i falls therefore updates immediately.
- Software update: ug_i=1 triggers an update regardless of udis_i or state, and rep_cnt <= rcr_preload_i.
- ug_i and ovf_i in the same cycle produce exactly one update; rep_cnt is reloaded, not decremented.
- Latency:
  - trigger at edge N gives update_event_o=1 for exactly the cycle after N;
  - uif_o rises at the same edge as update_event_o;
  - triggers on consecutive edges give back-to-back pulses.
- uif_o:
  - set on every update;
  - cleared by uif_clr_i;
  - simultaneous set and clear: set wins.
- Config write:
  - cfg_wr_i at edge N with locked_o=0: dtg_preload_o <= cfg_dtg_i at N, and cfg_ack_o=1, cfg_err_o=0 for the following cycle.
  - With locked_o=1: dtg_preload_o unchanged; cfg_ack_o=1, cfg_err_o=1.
  - cfg_err_o is 0 whenever cfg_ack_o=0.
- Write and trigger in the same cycle: the new value is already on dtg_preload_o when update_event_o is high, so the shadow loads the new value.
- Lock:
  - lock_set_i sets locked_o at the next edge; it clears only on reset.
  - lock_set_i and cfg_wr_i in the same cycle: the write is accepted, then the lock applies.
- rcr_preload_i is sampled only at reload edges. rcr_preload_i=0 means update on every enabled overflow.
- Reset mid-operation: any pending pulse, flag, count and lock are cleared immediately. No update is issued on reset release.

Decomposition:
- Shared timer package, pwm_timer_pkg, holds:
  - state enum (ST_IDLE, ST_RUN);
  - default widths (WIDTH=8, RCR_WIDTH=8).
- One natural sub-module, pwm_rep_counter: the repetition down-counter with reload, hold and expiry logic. It takes ovf_en, udis and force inputs and outputs a trigger.
- Config/lock register and the FSM stay in the top level.

Test Plan:
- Reset, then cen_i=1, rcr_preload_i=0, four ovf_i pulses → four update_event_o pulses, each one cycle after its ovf_i; uif_o=1 after the first.
- rcr_preload_i=2, six ovf_i pulses:
  - updates on the 1st and 4th pulses only;
  - rep_cnt_o sequence 2,1,0,2,1,0.
- udis_i=1 with rep_cnt=0, then three ovf_i → no updates; udis_i=0, next ovf_i → update. ug_i while udis_i=1 → update, rep_cnt_o reloaded.
- cfg_wr_i cfg_dtg_i=3, then ug_i → dtg_preload_o=3 before update_event_o; driven pwm_oc_deadtime shows 3-cycle delay on pwm_high_o.
- cfg_wr_i=5 in the same cycle as a triggering ovf_i → update pulse sees dtg_preload_o=5.
- lock_set_i, then cfg_wr_i=7 → cfg_ack_o=1 with cfg_err_o=1; dtg_preload_o unchanged. Assert rst_n_i=0 mid-count → all outputs 0 and locked_o=0 immediately.
